// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD text sequencer: FSM states, the HD44780
// 8-bit init ROM and the DDRAM line-address commands.
package lcd_pkg;

   typedef enum logic [3:0] {
      S_PWRUP = 4'd0,
      S_INIT  = 4'd1,
      S_IWAIT = 4'd2,
      S_IDLE  = 4'd3,
      S_LADDR = 4'd4,
      S_LWAIT = 4'd5,
      S_FETCH = 4'd6,
      S_CHAR  = 4'd7,
      S_CWAIT = 4'd8
   } state_t;

   localparam int         INIT_LEN       = 6;
   localparam int         CLR_INDEX      = 4;
   localparam logic [7:0] LINE1_ADDR     = 8'h80;
   localparam logic [7:0] LINE2_ADDR     = 8'hC0;
   localparam int         CHARS_PER_LINE = 16;

   // Function set x3, display on, clear, entry mode increment.
   function automatic logic [7:0] init_rom(input logic [2:0] idx);
      case (idx)
         3'd0, 3'd1, 3'd2: init_rom = 8'h38;
         3'd3:             init_rom = 8'h0C;
         3'd4:             init_rom = 8'h01;
         3'd5:             init_rom = 8'h06;
         default:          init_rom = 8'h00;
      endcase
   endfunction

endpackage

// File: rtl/lcd_wait_cnt.sv
// Post-command wait counter: loads on a command strobe, counts down to zero
// and flags the last cycle of the wait so the next action lands exactly on time.
module lcd_wait_cnt #(
   parameter int unsigned CNT_W   = 21,
   parameter int unsigned RST_VAL = 0
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   output logic             expire
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cnt_q <= CNT_W'(RST_VAL);
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // High while the counter steps to zero, so the caller's state change
   // completes as the count reaches zero.
   assign expire = (cnt_q <= CNT_W'(1));

endmodule

// File: rtl/lcd_text_seq.sv
// LCD command sequencer: runs the HD44780 init sequence after power-up, then
// refreshes a 2x16 display from a 32-byte text RAM on request or continuously.
module lcd_text_seq #(
   parameter int unsigned PWRUP_WAIT = 1500000,
   parameter int unsigned CMD_GAP    = 5000,
   parameter int unsigned CLR_WAIT   = 170000,
   parameter int unsigned CNT_W      = 21
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic       refresh_req,
   input  logic       auto_refresh,
   output logic [4:0] ram_addr,
   input  logic [7:0] ram_data,
   output logic [7:0] db_out,
   output logic       rs_out,
   output logic       rwb_out,
   output logic       instr,
   output logic       cmmd,
   output logic       init_done,
   output logic       busy
);
   import lcd_pkg::*;

   state_t           state_q, state_d;
   logic [2:0]       idx_q, idx_d;
   logic             pend_q, pend_d, pend_clr;
   logic [4:0]       ram_addr_q, ram_addr_d;
   logic [7:0]       db_q, db_d;
   logic             rs_q, rs_d;
   logic             instr_q, instr_d;
   logic             cmmd_q, cmmd_d;
   logic             init_done_q, init_done_d;
   logic             busy_q, busy_d;
   logic             cnt_load;
   logic [CNT_W-1:0] cnt_val;
   logic             cnt_expire;
   logic             want_refresh;

   lcd_wait_cnt #(
      .CNT_W   (CNT_W),
      .RST_VAL (PWRUP_WAIT)
   ) u_wait (
      .clk      (clk),
      .rstn     (rstn),
      .load     (cnt_load),
      .load_val (cnt_val),
      .expire   (cnt_expire)
   );

   assign want_refresh = pend_q | auto_refresh;

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      ram_addr_d  = ram_addr_q;
      db_d        = db_q;
      rs_d        = rs_q;
      instr_d     = instr_q;
      cmmd_d      = 1'b0;
      init_done_d = init_done_q;
      cnt_load    = 1'b0;
      cnt_val     = CNT_W'(CMD_GAP);
      pend_clr    = 1'b0;
      case (state_q)
         S_PWRUP: if (cnt_expire) state_d = S_INIT;
         S_INIT: begin
            db_d     = init_rom(idx_q);
            rs_d     = 1'b0;
            instr_d  = 1'b1;
            cmmd_d   = 1'b1;
            cnt_load = 1'b1;
            if (idx_q == 3'(CLR_INDEX)) cnt_val = CNT_W'(CLR_WAIT);
            state_d  = S_IWAIT;
         end
         S_IWAIT: if (cnt_expire) begin
            if (idx_q == 3'(INIT_LEN - 1)) begin
               idx_d       = '0;
               init_done_d = 1'b1;
               state_d     = S_IDLE;
            end else begin
               idx_d   = idx_q + 3'd1;
               state_d = S_INIT;
            end
         end
         S_IDLE: if (want_refresh) begin
            pend_clr = 1'b1;
            state_d  = S_LADDR;
         end
         S_LADDR: begin
            // ram_addr already sits at 0 or 16 here; bit 4 selects the line.
            db_d       = ram_addr_q[4] ? LINE2_ADDR : LINE1_ADDR;
            rs_d       = 1'b0;
            instr_d    = 1'b1;
            cmmd_d     = 1'b1;
            cnt_load   = 1'b1;
            ram_addr_d = {ram_addr_q[4], 4'd0};
            state_d    = S_LWAIT;
         end
         S_LWAIT: if (cnt_expire) state_d = S_FETCH;
         S_FETCH: state_d = S_CHAR;
         S_CHAR: begin
            db_d       = ram_data;
            rs_d       = 1'b1;
            instr_d    = 1'b0;
            cmmd_d     = 1'b1;
            cnt_load   = 1'b1;
            ram_addr_d = ram_addr_q + 5'd1;
            state_d    = S_CWAIT;
         end
         S_CWAIT: if (cnt_expire) begin
            if (ram_addr_q == 5'(CHARS_PER_LINE)) begin
               state_d = S_LADDR;
            end else if (ram_addr_q == 5'd0) begin
               // Chain straight into the next refresh so repeats have no idle gap.
               if (want_refresh) begin
                  pend_clr = 1'b1;
                  state_d  = S_LADDR;
               end else begin
                  state_d  = S_IDLE;
               end
            end else begin
               state_d = S_FETCH;
            end
         end
         default: begin
            state_d  = S_PWRUP;
            idx_d    = '0;
            cnt_load = 1'b1;
            cnt_val  = CNT_W'(PWRUP_WAIT);
         end
      endcase
      pend_d = refresh_req | (pend_q & ~pend_clr);
      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q     <= S_PWRUP;
         idx_q       <= '0;
         pend_q      <= 1'b0;
         ram_addr_q  <= '0;
         db_q        <= '0;
         rs_q        <= 1'b0;
         instr_q     <= 1'b0;
         cmmd_q      <= 1'b0;
         init_done_q <= 1'b0;
         busy_q      <= 1'b1;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         pend_q      <= pend_d;
         ram_addr_q  <= ram_addr_d;
         db_q        <= db_d;
         rs_q        <= rs_d;
         instr_q     <= instr_d;
         cmmd_q      <= cmmd_d;
         init_done_q <= init_done_d;
         busy_q      <= busy_d;
      end
   end

   assign ram_addr  = ram_addr_q;
   assign db_out    = db_q;
   assign rs_out    = rs_q;
   assign rwb_out   = 1'b0;
   assign instr     = instr_q;
   assign cmmd      = cmmd_q;
   assign init_done = init_done_q;
   assign busy      = busy_q;

endmodule
